// File: rtl/seq_signed_divider.sv
// ----------------------------------------------------------------------------
// seq_signed_divider
//   Iterative restoring divider for the multicycle datapath. The divider
//   produces one quotient bit per clock. After a start pulse, the quotient and
//   remainder are valid WIDTH+1 clocks later, flagged by a one-cycle oDone.
//
//   Build option:
//     SIGNED_DIV_EN defined   : operands are two's complement. The quotient
//                               truncates toward zero. The remainder takes the
//                               sign of the dividend.
//     SIGNED_DIV_EN undefined : operands are unsigned.
//
//   Ports:
//     iClk        system clock, rising edge
//     iReset_n    asynchronous active-low reset
//     iStart      start request, sampled only while oBusy = 0
//     iDividend   dividend, captured on an accepted start
//     iDivisor    divisor, captured on an accepted start
//     oBusy       high while a division is in progress
//     oDone       one-cycle pulse when the results become valid
//     oQuotient   quotient, held until the next completion
//     oRemainder  remainder, held until the next completion
//     oDivZero    divisor was zero for the last completed division
// ----------------------------------------------------------------------------
module seq_signed_divider #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic             iStart,
   input  logic [WIDTH-1:0] iDividend,
   input  logic [WIDTH-1:0] iDivisor,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oQuotient,
   output logic [WIDTH-1:0] oRemainder,
   output logic             oDivZero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             dz_q;
`ifdef SIGNED_DIV_EN
   logic             dvd_neg_q;
   logic             dvs_neg_q;
   logic             dvd_neg;
   logic             dvs_neg;
`endif

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   shift_w;
   logic             ge;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // Operand magnitudes at capture time.
   always_comb begin
      dvd_mag = iDividend;
      dvs_mag = iDivisor;
`ifdef SIGNED_DIV_EN
      dvd_neg = iDividend[WIDTH-1];
      dvs_neg = iDivisor[WIDTH-1];
      if (dvd_neg) dvd_mag = ~iDividend + ONE;
      if (dvs_neg) dvs_mag = ~iDivisor + ONE;
`endif
   end

   // One restoring step. The remainder is always smaller than the divisor,
   // so it fits in WIDTH bits. Only the shifted value needs an extra bit.
   // A subtraction that wraps modulo 2^WIDTH still gives the correct result.
   always_comb begin
      shift_w = {rem_q, quo_q[WIDTH-1]};
      ge      = (shift_w >= {1'b0, dvs_q});
      rem_d   = ge ? (shift_w[WIDTH-1:0] - dvs_q) : shift_w[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
   end

   // Final result correction.
   // With a zero divisor, every trial succeeds. The quotient becomes all
   // ones, and the dividend magnitude shifts fully into rem_q. Applying the
   // remainder sign rule therefore returns the original dividend unchanged.
   always_comb begin
      quo_fix = quo_q;
      rem_fix = rem_q;
`ifdef SIGNED_DIV_EN
      if (dvd_neg_q ^ dvs_neg_q) quo_fix = ~quo_q + ONE;
      if (dvd_neg_q)             rem_fix = ~rem_q + ONE;
`endif
      if (dz_q) quo_fix = '1;
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         dz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
         dvd_neg_q  <= 1'b0;
         dvs_neg_q  <= 1'b0;
`endif
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oQuotient  <= '0;
         oRemainder <= '0;
         oDivZero   <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iStart) begin
                  state_q   <= S_CALC;
                  cnt_q     <= CNT_MAX;
                  rem_q     <= '0;
                  quo_q     <= dvd_mag;
                  dvs_q     <= dvs_mag;
                  dz_q      <= (iDivisor == '0);
`ifdef SIGNED_DIV_EN
                  dvd_neg_q <= dvd_neg;
                  dvs_neg_q <= dvs_neg;
`endif
                  oBusy     <= 1'b1;
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_q <= S_FIN;
            end
            S_FIN: begin
               oQuotient  <= quo_fix;
               oRemainder <= rem_fix;
               oDivZero   <= dz_q;
               oDone      <= 1'b1;
               oBusy      <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               oBusy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
